// File: rtl/hash_wb_fsm.sv
// Writes a captured HASH_W-bit hash to a bus master as NUM_BEATS DATA_W-bit beats, least-significant slice first.
// Optional watchdog on the master handshake: define HASH_WB_TIMEOUT_EN.
//
// state       | meaning
// IDLE        | waiting for start
// ARMED       | waiting for hash_valid to capture hash_in
// ISSUE       | load the current beat and launch one master transaction
// WAIT_ACTIVE | waiting for the master to accept the transaction
// WAIT_DONE   | waiting for the master to complete the transaction
// DONE        | all beats written; done held high
// ERROR       | watchdog expired; error held high
module hash_wb_fsm #(
    parameter int DATA_W      = 128,
    parameter int HASH_W      = 512,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [HASH_W-1:0] hash_in,
    input  logic              hash_valid,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_data_valid,
    output logic [31:0]       write_addr_index,
    output logic              init_master_txn,
    input  logic              write_active,
    input  logic              write_done,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       debug
);

    localparam int NUM_BEATS = HASH_W / DATA_W;

    if ((HASH_W % DATA_W) != 0 || NUM_BEATS > 255 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("hash_wb_fsm: HASH_W must be a multiple of DATA_W (at most 255 beats) and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ARMED       = 3'd1,
        ISSUE       = 3'd2,
        WAIT_ACTIVE = 3'd3,
        WAIT_DONE   = 3'd4,
        DONE        = 3'd5,
        ERROR       = 3'd6
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        beat_cnt;
    logic [HASH_W-1:0] shadow;
    logic [DATA_W-1:0] cur_beat;
    logic              last_beat;
    logic              beat_done;
    logic              wd_expired;

    assign last_beat = (beat_cnt == 8'(NUM_BEATS - 1));

    // Accept-and-complete in the same WAIT_ACTIVE cycle counts as completion.
    assign beat_done = ((state == WAIT_DONE) && write_done) ||
                       ((state == WAIT_ACTIVE) && write_active && write_done);

    always_comb begin
        cur_beat = '0;
        for (int k = 0; k < NUM_BEATS; k++) begin
            if (beat_cnt == 8'(k)) cur_beat = shadow[k*DATA_W +: DATA_W];
        end
    end

`ifdef HASH_WB_TIMEOUT_EN
    logic [31:0] wd_cnt;

    // Reloaded on entry to each wait state; expiry on the TIMEOUT_CYC-th cycle spent there.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if ((state == ISSUE) || ((state == WAIT_ACTIVE) && write_active)) begin
            wd_cnt <= 32'(TIMEOUT_CYC - 1);
        end else if (((state == WAIT_ACTIVE) || (state == WAIT_DONE)) && (wd_cnt != '0)) begin
            wd_cnt <= wd_cnt - 32'd1;
        end
    end

    assign wd_expired = ((state == WAIT_ACTIVE) || (state == WAIT_DONE)) && (wd_cnt == '0);
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_nxt = ARMED;
            ARMED:             if (hash_valid) state_nxt = ISSUE;
            ISSUE:             state_nxt = WAIT_ACTIVE;
            WAIT_ACTIVE: begin
                if (write_active) begin
                    if (write_done) state_nxt = last_beat ? DONE : ISSUE;
                    else            state_nxt = WAIT_DONE;
                end else if (wd_expired) begin
                    state_nxt = ERROR;
                end
            end
            WAIT_DONE: begin
                if (write_done)      state_nxt = last_beat ? DONE : ISSUE;
                else if (wd_expired) state_nxt = ERROR;
            end
            default:           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE) && (state != DONE);
        done  = (state == DONE);
`ifdef HASH_WB_TIMEOUT_EN
        error = (state == ERROR);
`else
        error = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_data          <= '0;
            wr_data_valid    <= 1'b0;
            write_addr_index <= '0;
            init_master_txn  <= 1'b0;
            shadow           <= '0;
            beat_cnt         <= '0;
        end else begin
            init_master_txn <= (state == ISSUE);
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        write_addr_index <= '0;
                        beat_cnt         <= '0;
                    end
                end
                ARMED: if (hash_valid) shadow <= hash_in;
                ISSUE: begin
                    wr_data       <= cur_beat;
                    wr_data_valid <= 1'b1;
                end
                WAIT_ACTIVE, WAIT_DONE: begin
                    if (beat_done) begin
                        wr_data_valid    <= 1'b0;
                        write_addr_index <= write_addr_index + 32'd1;
                        beat_cnt         <= beat_cnt + 8'd1;
                    end else if (wd_expired) begin
                        wr_data_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign debug = {16'b0, beat_cnt, 1'b0, state, write_active, write_done,
                    init_master_txn, wr_data_valid};

endmodule

// File: doc/hash_wb_fsm.md
HASH_WB_FSM -- requirements
Module: hash_wb_fsm

Interface
REQ-001 Parameter DATA_W, 128, width of one bus write beat in bits.
REQ-002 Parameter HASH_W, 512, hash width in bits; SHALL be an integer multiple of DATA_W; NUM_BEATS = HASH_W/DATA_W.
REQ-003 Parameter TIMEOUT_CYC, 1024, watchdog limit in cycles (used only under HASH_WB_TIMEOUT_EN).
REQ-004 clk  in  1  clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; arms a write-back.
REQ-007 hash_in  in  HASH_W  hash result from the Keccak core.
REQ-008 hash_valid  in  1  hash_in valid (Keccak out_ready, level).
REQ-009 wr_data  out  DATA_W  current beat presented to the bus master.
REQ-010 wr_data_valid  out  1  wr_data stable and valid for the current transaction.
REQ-011 write_addr_index  out  32  beat index the master uses to form the write address.
REQ-012 init_master_txn  out  1  one-cycle pulse that launches one master write transaction.
REQ-013 write_active  in  1  master has accepted the transaction.
REQ-014 write_done  in  1  master has completed the transaction (pulse).
REQ-015 busy  out  1  high in every state except IDLE and DONE.
REQ-016 done  out  1  high (level) in DONE.
REQ-017 error  out  1  watchdog expiry flag.
REQ-018 debug  out  32  {16'b0, beat_cnt[7:0], 1'b0, state[2:0], write_active, write_done, init_master_txn, wr_data_valid}.

Function
REQ-019 States SHALL be IDLE, ARMED, ISSUE, WAIT_ACTIVE, WAIT_DONE, DONE, ERROR.
REQ-020 IDLE/DONE/ERROR: start -> ARMED; write_addr_index, beat_cnt, done, error cleared on the same edge.
REQ-021 ARMED: hash_valid high -> copy hash_in into an internal HASH_W shadow register, go ISSUE; else stay.
REQ-022 ISSUE: wr_data <= shadow[DATA_W*beat_cnt +: DATA_W], wr_data_valid <= 1, init_master_txn <= 1 for exactly one cycle, go WAIT_ACTIVE.
REQ-023 WAIT_ACTIVE: init_master_txn low; write_active -> WAIT_DONE; write_active and write_done in the same cycle SHALL be treated as completion (REQ-024 action taken directly).
REQ-024 WAIT_DONE: write_done -> wr_data_valid <= 0, write_addr_index +1, beat_cnt +1; if beat_cnt was NUM_BEATS-1 go DONE, else go ISSUE.
REQ-025 Beat order SHALL be least-significant DATA_W slice first; wr_data SHALL stay constant from ISSUE until write_done.
REQ-026 start received outside IDLE/DONE/ERROR SHALL be ignored; write_done or write_active outside WAIT_ACTIVE/WAIT_DONE SHALL be ignored.
REQ-027 Changes on hash_in after capture SHALL NOT affect emitted data.
REQ-028 Minimum per-beat cost: 3 cycles (ISSUE, WAIT_ACTIVE, WAIT_DONE) when master responds immediately; write_addr_index arithmetic SHALL wrap modulo 2^32.

Reset
REQ-029 While reset is high at a clock edge: state=IDLE; wr_data=0, wr_data_valid=0, write_addr_index=0, init_master_txn=0, busy=0, done=0, error=0, shadow=0, beat_cnt=0.
REQ-030 Reset asserted mid-transaction SHALL abort immediately with no further init_master_txn pulse.

Configuration
REQ-031 Macro HASH_WB_TIMEOUT_EN defined: a counter cleared on entry to WAIT_ACTIVE and on WAIT_ACTIVE->WAIT_DONE; reaching TIMEOUT_CYC in either state -> ERROR, error=1, wr_data_valid=0.
REQ-032 Macro HASH_WB_TIMEOUT_EN undefined: no counter, ERROR unreachable, error tied to 0, waits are unbounded.

Verification
REQ-033 start, hash_valid one cycle later with hash_in = 0x00..03_00..02_00..01_00..00 (beat k = k), master responds immediately -> four init_master_txn pulses, wr_data 0,1,2,3 at index 0,1,2,3, done after 12 cycles from ISSUE.
REQ-034 start with hash_valid low for 50 cycles -> remains ARMED, no init_master_txn; then hash_valid -> normal 4-beat sequence.
REQ-035 write_active and write_done asserted together each beat -> 2 cycles per beat, all 4 beats correct, index ends at 4.
REQ-036 reset asserted during WAIT_DONE of beat 2 -> next cycle all outputs zero, state IDLE, no further pulses; new start completes normally from index 0.
REQ-037 HASH_WB_TIMEOUT_EN defined, write_active never asserted -> error=1 exactly TIMEOUT_CYC cycles after entering WAIT_ACTIVE; start clears it.
REQ-038 start pulse during WAIT_DONE of beat 1 -> ignored; sequence completes with exactly 4 transactions.
